// File: rtl/tdc_ts_fifo.sv
// Per-channel TDC timestamp buffer: last-timestamp snapshot, 128-bit FIFO read
// through a 32-bit Wishbone classic slave, and a threshold/timeout interrupt.
module tdc_ts_fifo #(
  parameter int g_depth     = 64,
  parameter int g_cnt_width = 7
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [127:0] ts_i,
  input  logic         ts_valid_i,
  input  logic         tick_1ms_i,
  input  logic [5:0]   wb_adr_i,
  input  logic [31:0]  wb_dat_i,
  output logic [31:0]  wb_dat_o,
  input  logic         wb_cyc_i,
  input  logic         wb_stb_i,
  input  logic         wb_we_i,
  input  logic [3:0]   wb_sel_i,
  output logic         wb_ack_o,
  output logic         wb_stall_o,
  output logic         irq_o
);
  localparam int PW = $clog2(g_depth);

  typedef enum logic [3:0] {
    R_CSR = 4'd0, R_LTS0 = 4'd1, R_LTS1 = 4'd2, R_LTS2 = 4'd3, R_LTS3 = 4'd4,
    R_FCSR = 4'd5, R_F0 = 4'd6, R_F1 = 4'd7, R_F2 = 4'd8, R_F3 = 4'd9,
    R_THR = 4'd10, R_TMO = 4'd11
  } reg_e;

  logic [127:0]           mem [g_depth];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [g_cnt_width-1:0] count;
  logic [127:0]           lts, head;
  logic                   last_valid, overflow;
  logic [15:0]            thr, tmo, timer;
  logic                   acc, acc_rd, acc_wr, full, empty, push, pop, drop;
  logic [3:0]             idx;
  logic [31:0]            rd_mux;
  logic                   unused;

  assign unused     = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:16]};
  assign wb_stall_o = 1'b0;

  // A new access is accepted only when no ack is outstanding, so ack never repeats.
  assign acc    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign acc_rd = acc & ~wb_we_i;
  assign acc_wr = acc & wb_we_i;
  assign idx    = wb_adr_i[5:2];

  assign full  = (count == g_cnt_width'(g_depth));
  assign empty = (count == '0);
  assign push  = ts_valid_i & ~full;
  assign drop  = ts_valid_i & full;
  assign pop   = acc_rd & (idx == R_F3) & ~empty;
  assign head  = mem[rd_ptr];

  always_comb begin
    rd_mux = '0;
    case (idx)
      R_CSR:  rd_mux[1:0] = {overflow, last_valid};
      R_LTS0: rd_mux = lts[31:0];
      R_LTS1: rd_mux = lts[63:32];
      R_LTS2: rd_mux = lts[95:64];
      R_LTS3: rd_mux = lts[127:96];
      R_FCSR: begin
        rd_mux[g_cnt_width-1:0] = count;
        rd_mux[16] = full;
        rd_mux[17] = empty;
      end
      R_F0:   rd_mux = head[31:0];
      R_F1:   rd_mux = head[63:32];
      R_F2:   rd_mux = head[95:64];
      R_F3:   rd_mux = head[127:96];
      R_THR:  rd_mux[15:0] = thr;
      R_TMO:  rd_mux[15:0] = tmo;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= ts_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lts        <= '0;
      last_valid <= 1'b0;
      overflow   <= 1'b0;
      thr        <= 16'd1;
      tmo        <= 16'd10;
      timer      <= '0;
      irq_o      <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= acc_rd ? rd_mux : '0;

      if (acc_wr && idx == R_THR) thr <= wb_dat_i[15:0];
      if (acc_wr && idx == R_TMO) tmo <= wb_dat_i[15:0];

      // Capture events take priority over software clears in the same cycle.
      if (ts_valid_i) begin
        lts        <= ts_i;
        last_valid <= 1'b1;
      end else if (acc_wr && idx == R_CSR && !wb_dat_i[0]) begin
        last_valid <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
      else if (acc_wr && idx == R_CSR) overflow <= 1'b0;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (empty) timer <= '0;
      else if (tick_1ms_i && timer != 16'hFFFF) timer <= timer + 1'b1;

      irq_o <= ((thr != 16'd0) && (16'(count) >= thr)) ||
               ((tmo != 16'd0) && (timer >= tmo) && !empty);
    end
  end
endmodule

// File: tb/tb_tdc_ts_fifo.sv
// Directed bench for tdc_ts_fifo: register map, capture, FIFO order,
// interrupt sources, overflow, simultaneous push/pop and reset mid-access.
module tb_tdc_ts_fifo;
  logic         clk = 0;
  logic         rst_n = 0;
  logic [127:0] ts = '0;
  logic         ts_valid = 0, tick = 0;
  logic [5:0]   adr = '0;
  logic [31:0]  dat_w = '0, dat_r;
  logic         cyc = 0, stb = 0, we = 0;
  logic [3:0]   sel = 4'hF;
  logic         ack, stall, irq;
  int           total = 0, bad = 0;

  tdc_ts_fifo #(.g_depth(64), .g_cnt_width(7)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ts_i(ts), .ts_valid_i(ts_valid),
    .tick_1ms_i(tick), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_ack_o(ack), .wb_stall_o(stall), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic wb_rd(input logic [5:0] a, output logic [31:0] d);
    logic ok = 0;
    d = '0;
    @(negedge clk); adr = a; we = 0; cyc = 1; stb = 1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1; d = dat_r; end
    end
    cyc = 0; stb = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL wb_rd_timeout adr=%h got no ack, need ack", a);
    end
  endtask

  task automatic wb_wr(input logic [5:0] a, input logic [31:0] d);
    logic ok = 0;
    @(negedge clk); adr = a; dat_w = d; we = 1; cyc = 1; stb = 1;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      if (ack) ok = 1;
    end
    cyc = 0; stb = 0; we = 0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL wb_wr_timeout adr=%h got no ack, need ack", a);
    end
  endtask

  task automatic push(input logic [127:0] v);
    @(negedge clk); ts = v; ts_valid = 1;
    @(negedge clk); ts_valid = 0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1;
    @(negedge clk); tick = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [127:0] pat(input int i);
    return {32'(i + 32'h300), 32'(i + 32'h200), 32'(i + 32'h100), 32'(i)};
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_r [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00020000,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'hA};
    rst_n = 0; wait_cyc(3); rst_n = 1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b need=0", irq); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b need=0", ack); end
    for (int r = 0; r < 12; r++) begin
      wb_rd(6'(r * 4), d);
      total++;
      if (d !== exp_r[r]) begin bad++; $display("FAIL reset_reg%0d got=%h need=%h", r, d, exp_r[r]); end
    end
    wb_rd(6'h30, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h need=0", d); end
  endtask

  task automatic test_capture();
    logic [31:0] d;
    logic [127:0] v = 128'h44444444_33333333_22222222_11111111;
    push(v);
    wb_rd(6'h00, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL cap_csr got=%h need=1", d); end
    for (int w = 0; w < 4; w++) begin
      wb_rd(6'(4 + 4 * w), d);
      total++; if (d !== v[32*w +: 32]) begin bad++; $display("FAIL cap_lts%0d got=%h need=%h", w, d, v[32*w +: 32]); end
    end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL cap_irq_thr1 got=%b need=1", irq); end
    wb_wr(6'h00, 32'h1);
    wb_rd(6'h00, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL csr_w1_noeffect got=%h need=1", d); end
    wb_wr(6'h00, 32'h0);
    wb_rd(6'h00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL csr_clear got=%h need=0", d); end
    wb_rd(6'h04, d);
    total++; if (d !== 32'h11111111) begin bad++; $display("FAIL lts_kept got=%h need=11111111", d); end
    wb_rd(6'h24, d);
    total++; if (d !== 32'h44444444) begin bad++; $display("FAIL cap_pop got=%h need=44444444", d); end
    wb_rd(6'h14, d);
    total++; if (d !== 32'h00020000) begin bad++; $display("FAIL cap_empty got=%h need=00020000", d); end
  endtask

  task automatic test_threshold();
    logic [31:0] d;
    logic [127:0] a = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    logic [127:0] b = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    wb_wr(6'h28, 32'd2);
    wb_wr(6'h2C, 32'd0);
    push(a); wait_cyc(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_cnt1 got=%b need=0", irq); end
    push(b); wait_cyc(2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL thr_cnt2 got=%b need=1", irq); end
    for (int w = 0; w < 4; w++) begin
      wb_rd(6'(24 + 4 * w), d);
      total++; if (d !== a[32*w +: 32]) begin bad++; $display("FAIL thr_a%0d got=%h need=%h", w, d, a[32*w +: 32]); end
    end
    wait_cyc(2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL thr_drain_irq got=%b need=0", irq); end
    wb_rd(6'h14, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL thr_cnt_after got=%h need=1", d); end
    for (int w = 0; w < 4; w++) begin
      wb_rd(6'(24 + 4 * w), d);
      total++; if (d !== b[32*w +: 32]) begin bad++; $display("FAIL thr_b%0d got=%h need=%h", w, d, b[32*w +: 32]); end
    end
    wb_rd(6'h14, d);
    total++; if (d !== 32'h00020000) begin bad++; $display("FAIL thr_empty got=%h need=00020000", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    wb_wr(6'h28, 32'd100);
    wb_wr(6'h2C, 32'd10);
    for (int pass = 0; pass < 2; pass++) begin
      push(pat(pass + 500));
      repeat (9) pulse_tick();
      wait_cyc(2);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL tmo_9ticks pass%0d got=%b need=0", pass, irq); end
      if (pass == 0) begin
        pulse_tick(); wait_cyc(2);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL tmo_10ticks got=%b need=1", irq); end
      end
      wb_rd(6'h24, d);
      wait_cyc(2);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL tmo_pop pass%0d got=%b need=0", pass, irq); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [127:0] e;
    for (int i = 0; i <= 64; i++) push(pat(i));
    wb_rd(6'h14, d);
    total++; if (d !== 32'h00010040) begin bad++; $display("FAIL ovf_fcsr got=%h need=00010040", d); end
    wb_rd(6'h00, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL ovf_csr got=%h need=3", d); end
    wb_rd(6'h04, d);
    total++; if (d !== 32'd64) begin bad++; $display("FAIL ovf_lts0 got=%h need=40", d); end
    wb_wr(6'h00, 32'h1);
    wb_rd(6'h00, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL ovf_clear got=%h need=1", d); end
    for (int i = 0; i < 64; i++) begin
      e = pat(i);
      wb_rd(6'h18, d);
      total++; if (d !== e[31:0]) begin bad++; $display("FAIL drain%0d_w0 got=%h need=%h", i, d, e[31:0]); end
      wb_rd(6'h24, d);
      total++; if (d !== e[127:96]) begin bad++; $display("FAIL drain%0d_w3 got=%h need=%h", i, d, e[127:96]); end
    end
    wb_rd(6'h14, d);
    total++; if (d !== 32'h00020000) begin bad++; $display("FAIL drain_empty got=%h need=00020000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [127:0] p3 = pat(803);
    for (int i = 0; i < 3; i++) push(pat(800 + i));
    @(negedge clk); adr = 6'h24; we = 0; cyc = 1; stb = 1; ts = p3; ts_valid = 1;
    @(posedge clk); #1;
    cyc = 0; stb = 0; ts_valid = 0;
    e_chk: begin
      logic [127:0] p0 = pat(800);
      total++; if (ack !== 1'b1 || dat_r !== p0[127:96]) begin
        bad++; $display("FAIL b2b_r3 got ack=%b dat=%h need ack=1 dat=%h", ack, dat_r, p0[127:96]);
      end
    end
    wb_rd(6'h14, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL b2b_count got=%h need=3", d); end
    wb_rd(6'h18, d);
    total++; if (d !== 32'd801) begin bad++; $display("FAIL b2b_head got=%h need=%h", d, 32'd801); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    @(negedge clk); rst_n = 0; adr = 6'h14; we = 0; cyc = 1; stb = 1;
    @(posedge clk); #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_mid_ack got=%b need=0", ack); end
    @(negedge clk); cyc = 0; stb = 0; rst_n = 1;
    wb_rd(6'h14, d);
    total++; if (d !== 32'h00020000) begin bad++; $display("FAIL rst_mid_empty got=%h need=00020000", d); end
    wb_rd(6'h28, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL rst_mid_thr got=%h need=1", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_mid_irq got=%b need=0", irq); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_threshold();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
